uart_tx_scheduler: RTL and testbench

- Sits in front of the UART transmitter (1 MBaud, 8N1) and shares it between two byte sources: the CPU MMIO port and the debug/boot port.
- Round-robin arbitration pushes bytes into an internal TX FIFO.
- A sequencer drains the FIFO one byte at a time using the transmitter's DV/Done handshake.
- The CPU no longer has to busy-wait on the transmitter per byte.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_scheduler_sync_fifo.sv | 71 +++++++
 rtl/uart_tx_scheduler.sv | 110 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART TX scheduler: sequencer states, arbiter grants
// and the default FIFO sizing.
package uart_pkg;

   localparam int FIFO_AW_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_SEND    = 2'd2,
      S_RELEASE = 2'd3
   } seq_state_e;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_DBG = 1'b1
   } grant_e;

endpackage

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Synchronous circular FIFO with registered read data, occupancy count and a
// single-cycle flush. Also intended for RX buffering.
module sync_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [DW-1:0] rdata_o,
   output logic [AW:0]   count_o,
   output logic          empty_o,
   output logic          full_o
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [DW-1:0] rdata_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = rdata_q;

   // Full blocks a push even when a pop frees a slot in the same cycle.
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (flush_i) begin
         // A coincident pop still reads out its entry; the rest are dropped.
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (!do_push && do_pop) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_pop) rdata_q <= mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmitter between the CPU and debug byte sources:
// round-robin arbitration into a TX FIFO, drained via the DV/Done handshake.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int FIFO_AW = FIFO_AW_DEF
) (
   input  logic             i_Clock,
   input  logic             reset,
   input  logic             cpu_valid,
   input  logic [7:0]       cpu_data,
   output logic             cpu_ready,
   input  logic             dbg_valid,
   input  logic [7:0]       dbg_data,
   output logic             dbg_ready,
   input  logic             flush,
   output logic [FIFO_AW:0] fifo_count,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic             busy,
   output logic             tx_dv,
   output logic [7:0]       tx_byte,
   input  logic             tx_done,
   input  logic             tx_active
);

   seq_state_e state_q, state_d;
   grant_e     last_q, last_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic [7:0] fifo_rdata, push_data;
   logic       arb_ok, cpu_push, dbg_push, push, pop;
   logic       unused_tx_active;

   assign unused_tx_active = tx_active;

   // Arbiter: the requester that did not win last time has priority on a tie.
   assign arb_ok    = ~fifo_full & ~flush;
   assign cpu_ready = arb_ok & (~dbg_valid | (last_q == GNT_DBG));
   assign dbg_ready = arb_ok & (~cpu_valid | (last_q == GNT_CPU));
   assign cpu_push  = cpu_valid & cpu_ready;
   assign dbg_push  = dbg_valid & dbg_ready;
   assign push      = cpu_push | dbg_push;
   assign push_data = cpu_push ? cpu_data : dbg_data;

   always_comb begin
      last_d = last_q;
      if (cpu_push)      last_d = GNT_CPU;
      else if (dbg_push) last_d = GNT_DBG;
   end

   sync_fifo #(
      .DW (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk_i   (i_Clock),
      .rst_i   (reset),
      .push_i  (push),
      .wdata_i (push_data),
      .pop_i   (pop),
      .flush_i (flush),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Sequencer. S_RELEASE waits for Done to drop: the transmitter keeps Done
   // high one cycle into its idle state, so a fresh DV there would look done.
   always_comb begin
      state_d   = state_q;
      tx_byte_d = tx_byte_q;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            tx_byte_d = fifo_rdata;
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (tx_done) state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!tx_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         last_q    <= GNT_DBG;
         tx_byte_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         tx_byte_q <= tx_byte_d;
      end
   end

   assign tx_dv   = (state_q == S_SEND);
   assign tx_byte = tx_byte_q;
   assign busy    = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a cycle-compressed 8N1 transmitter
// model (Done held through cleanup and the first idle cycle).
module tb_uart_tx_scheduler;

   logic       i_Clock = 1'b0;
   logic       reset   = 1'b1;
   logic       cpu_valid = 1'b0, dbg_valid = 1'b0, flush = 1'b0;
   logic [7:0] cpu_data = 8'h00, dbg_data = 8'h00;
   logic       cpu_ready, dbg_ready, fifo_empty, fifo_full, busy, tx_dv;
   logic [4:0] fifo_count;
   logic [7:0] tx_byte;
   logic       tx_done, tx_active;

   logic       model_en = 1'b0, man_done = 1'b0;
   logic       m_done, m_busy;
   logic [7:0] m_byte;
   int         m_st, m_cnt;
   logic [7:0] rx_q [$];

   int n_cmp = 0;
   int n_fail = 0;

   always #5 i_Clock = ~i_Clock;

   uart_tx_scheduler #(.FIFO_AW(4)) dut (
      .i_Clock(i_Clock), .reset(reset),
      .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
      .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
      .flush(flush), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .busy(busy), .tx_dv(tx_dv), .tx_byte(tx_byte),
      .tx_done(tx_done), .tx_active(tx_active)
   );

   assign tx_done   = model_en ? m_done : man_done;
   assign tx_active = m_busy;

   // Transmitter model: 20 cycles of frame, one cleanup cycle, Done high
   // during cleanup and the first idle cycle.
   always @(posedge i_Clock or posedge reset) begin
      if (reset) begin
         m_st <= 0; m_cnt <= 0; m_done <= 1'b0; m_busy <= 1'b0; m_byte <= 8'h00;
      end else begin
         case (m_st)
            0: begin
               m_done <= 1'b0;
               if (model_en && tx_dv) begin
                  m_byte <= tx_byte; m_cnt <= 19; m_busy <= 1'b1; m_st <= 1;
               end
            end
            1: begin
               if (m_cnt == 0) begin m_done <= 1'b1; m_st <= 2; end
               else m_cnt <= m_cnt - 1;
            end
            default: begin
               m_busy <= 1'b0; rx_q.push_back(m_byte); m_st <= 0;
            end
         endcase
      end
   end

   task automatic do_reset();
      @(negedge i_Clock);
      reset = 1'b1; cpu_valid = 1'b0; dbg_valid = 1'b0; flush = 1'b0;
      man_done = 1'b0; model_en = 1'b0;
      repeat (2) @(negedge i_Clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL rst_tx_dv got %b exp 0", tx_dv); end
      n_cmp++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_tx_byte got %h exp 00", tx_byte); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_cmp++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_flags got e=%b f=%b exp e=1 f=0", fifo_empty, fifo_full); end
      n_cmp++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
      repeat (2) @(negedge i_Clock);
      reset = 1'b0;
      @(negedge i_Clock);
      cpu_valid = 1'b1; dbg_valid = 1'b1;
      #1;
      n_cmp++; if (cpu_ready !== 1'b1 || dbg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_first_tie got cpu=%b dbg=%b exp cpu=1 dbg=0", cpu_ready, dbg_ready); end
      #1;
      cpu_valid = 1'b0; dbg_valid = 1'b0;
   endtask

   task automatic test_single();
      int drops, rearm;
      do_reset();
      @(negedge i_Clock); cpu_valid = 1'b1; cpu_data = 8'h41;
      #1;
      n_cmp++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", cpu_ready); end
      @(negedge i_Clock); cpu_valid = 1'b0;
      n_cmp++; if (tx_dv !== 1'b0 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL single_c1 got dv=%b cnt=%0d exp dv=0 cnt=1", tx_dv, fifo_count); end
      @(negedge i_Clock);
      n_cmp++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL single_c2 got dv=%b exp 0", tx_dv); end
      @(negedge i_Clock);
      n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_c3 got dv=%b byte=%h exp dv=1 byte=41", tx_dv, tx_byte); end
      drops = 0;
      repeat (4) begin @(negedge i_Clock); if (tx_dv !== 1'b1) drops++; end
      n_cmp++; if (drops !== 0) begin n_fail++; $display("FAIL single_hold got %0d low cycles exp 0", drops); end
      man_done = 1'b1;
      @(negedge i_Clock);
      n_cmp++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL single_drop got dv=%b exp 0", tx_dv); end
      rearm = 0;
      repeat (3) begin @(negedge i_Clock); if (tx_dv !== 1'b0) rearm++; end
      n_cmp++; if (rearm !== 0) begin n_fail++; $display("FAIL single_release got %0d dv cycles exp 0", rearm); end
      man_done = 1'b0;
      @(negedge i_Clock);
      n_cmp++; if (busy !== 1'b0 || tx_dv !== 1'b0) begin n_fail++; $display("FAIL single_idle got busy=%b dv=%b exp 0 0", busy, tx_dv); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_q [8];
      logic [7:0] acc [$];
      int ci, di, it;
      exp_q = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
      do_reset();
      model_en = 1'b1; rx_q.delete();
      ci = 0; di = 0; it = 0;
      while ((ci < 4 || di < 4) && it < 40) begin
         @(negedge i_Clock);
         cpu_valid = (ci < 4); cpu_data = 8'(8'h10 + ci);
         dbg_valid = (di < 4); dbg_data = 8'(8'h20 + di);
         #1;
         if (cpu_valid && cpu_ready) begin acc.push_back(cpu_data); ci++; end
         else if (dbg_valid && dbg_ready) begin acc.push_back(dbg_data); di++; end
         it++;
      end
      @(negedge i_Clock); cpu_valid = 1'b0; dbg_valid = 1'b0;
      n_cmp++; if (acc.size() !== 8) begin n_fail++; $display("FAIL rr_accept_count got %0d exp 8", acc.size()); end
      for (int k = 0; k < 8 && k < acc.size(); k++) begin
         n_cmp++; if (acc[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr_accept[%0d] got %h exp %h", k, acc[k], exp_q[k]); end
      end
      for (int k = 0; k < 3000 && rx_q.size() < 8; k++) @(negedge i_Clock);
      n_cmp++; if (rx_q.size() !== 8) begin n_fail++; $display("FAIL rr_rx_count got %0d exp 8", rx_q.size()); end
      for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
         n_cmp++; if (rx_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr_rx[%0d] got %h exp %h", k, rx_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_full();
      int hits;
      do_reset();
      @(negedge i_Clock); cpu_valid = 1'b1; cpu_data = 8'hAA;
      @(negedge i_Clock); cpu_valid = 1'b0;
      repeat (2) @(negedge i_Clock);
      n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'hAA || fifo_count !== 5'd0) begin n_fail++; $display("FAIL full_first got dv=%b byte=%h cnt=%0d exp 1 AA 0", tx_dv, tx_byte, fifo_count); end
      hits = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge i_Clock); cpu_valid = 1'b1; cpu_data = 8'(i);
         #1; if (cpu_ready === 1'b1) hits++;
      end
      n_cmp++; if (hits !== 16) begin n_fail++; $display("FAIL full_accepts got %0d exp 16", hits); end
      @(negedge i_Clock); cpu_data = 8'h99;
      #1;
      n_cmp++; if (fifo_full !== 1'b1 || fifo_count !== 5'd16) begin n_fail++; $display("FAIL full_flag got full=%b cnt=%0d exp 1 16", fifo_full, fifo_count); end
      n_cmp++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready17 got %b exp 0", cpu_ready); end
      man_done = 1'b1;
      @(negedge i_Clock); man_done = 1'b0;
      #1; hits = (cpu_ready === 1'b1) ? 1 : 0;
      repeat (7) begin @(negedge i_Clock); #1; if (cpu_ready === 1'b1) hits++; end
      @(negedge i_Clock); cpu_valid = 1'b0;
      n_cmp++; if (hits !== 1) begin n_fail++; $display("FAIL full_after_pop got %0d accepts exp 1", hits); end
      n_cmp++; if (fifo_count !== 5'd16 || tx_dv !== 1'b1 || tx_byte !== 8'h01) begin n_fail++; $display("FAIL full_refill got cnt=%0d dv=%b byte=%h exp 16 1 01", fifo_count, tx_dv, tx_byte); end
   endtask

   task automatic test_wrap();
      int errs, stalls;
      do_reset();
      model_en = 1'b1; rx_q.delete();
      stalls = 0;
      for (int b = 0; b < 40; b++) begin
         @(negedge i_Clock); cpu_valid = 1'b1; cpu_data = 8'(b);
         #1;
         for (int k = 0; k < 2000 && cpu_ready !== 1'b1; k++) begin @(negedge i_Clock); #1; end
         if (cpu_ready !== 1'b1) stalls++;
      end
      @(negedge i_Clock); cpu_valid = 1'b0;
      n_cmp++; if (stalls !== 0) begin n_fail++; $display("FAIL wrap_push_timeout got %0d exp 0", stalls); end
      for (int k = 0; k < 4000 && rx_q.size() < 40; k++) @(negedge i_Clock);
      n_cmp++; if (rx_q.size() !== 40) begin n_fail++; $display("FAIL wrap_rx_count got %0d exp 40", rx_q.size()); end
      errs = 0;
      for (int k = 0; k < rx_q.size(); k++) begin
         if (rx_q[k] !== 8'(k)) begin
            errs++;
            if (errs < 4) $display("FAIL wrap_rx[%0d] got %h exp %h", k, rx_q[k], 8'(k));
         end
      end
      n_cmp++; if (errs !== 0) begin n_fail++; $display("FAIL wrap_order got %0d bad bytes exp 0", errs); end
   endtask

   task automatic test_flush();
      int extra;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge i_Clock); cpu_valid = 1'b1; cpu_data = 8'(8'h61 + i);
      end
      @(negedge i_Clock); cpu_valid = 1'b0;
      n_cmp++; if (fifo_count !== 5'd4 || tx_dv !== 1'b1 || tx_byte !== 8'h61) begin n_fail++; $display("FAIL flush_pre got cnt=%0d dv=%b byte=%h exp 4 1 61", fifo_count, tx_dv, tx_byte); end
      flush = 1'b1;
      #1;
      n_cmp++; if (cpu_ready !== 1'b0 || dbg_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got cpu=%b dbg=%b exp 0 0", cpu_ready, dbg_ready); end
      @(negedge i_Clock); flush = 1'b0;
      n_cmp++; if (fifo_count !== 5'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL flush_count got cnt=%0d empty=%b exp 0 1", fifo_count, fifo_empty); end
      n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'h61) begin n_fail++; $display("FAIL flush_inflight got dv=%b byte=%h exp 1 61", tx_dv, tx_byte); end
      man_done = 1'b1;
      @(negedge i_Clock); man_done = 1'b0;
      extra = 0;
      repeat (10) begin @(negedge i_Clock); if (tx_dv !== 1'b0) extra++; end
      n_cmp++; if (extra !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_after got dv_cycles=%0d busy=%b exp 0 0", extra, busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge i_Clock); cpu_valid = 1'b1; cpu_data = 8'h77;
      @(negedge i_Clock); cpu_valid = 1'b0;
      repeat (2) @(negedge i_Clock);
      n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'h77) begin n_fail++; $display("FAIL rmid_send got dv=%b byte=%h exp 1 77", tx_dv, tx_byte); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (tx_dv !== 1'b0 || fifo_empty !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async got dv=%b empty=%b busy=%b exp 0 1 0", tx_dv, fifo_empty, busy); end
      repeat (2) @(negedge i_Clock);
      reset = 1'b0;
      @(negedge i_Clock); cpu_valid = 1'b1; cpu_data = 8'h55;
      @(negedge i_Clock); cpu_valid = 1'b0;
      @(negedge i_Clock);
      n_cmp++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL rmid_early got dv=%b exp 0", tx_dv); end
      @(negedge i_Clock);
      n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'h55) begin n_fail++; $display("FAIL rmid_resend got dv=%b byte=%h exp 1 55", tx_dv, tx_byte); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_wrap();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
